tick_pwm: RTL and testbench
===========================

# tick_pwm

Tick-driven PWM generator that sits directly downstream of the loadable counter. It consumes the counter's one-cycle carry-out as its time-base tick and counts ticks modulo a programmable period. It drives a PWM waveform with programmable duty and flags each completed PWM period. It turns the counter's programmable frequency divider into a duty-controlled output, e.g. for LED brightness or motor drive on the lab board.

## Interface
- W, default 8: width of the period, duty and internal tick counter.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- en  input  1  run request; level-sensitive.
- tick  input  1  time-base strobe, one clk cycle wide; connects to the counter's carry-out.
- period  input  W  last tick index of a PWM period; the period lasts period+1 ticks.
- duty  input  W  number of ticks per period during which pwm_out is high.
- pwm_out  output  1  PWM waveform, registered.
- cyc_done  output  1  one-cycle pulse on the clk cycle in which a period completes, registered.
- busy  output  1  high while in RUN, registered.

## Operation
- Two states: IDLE and RUN. Internal registers:
  - cnt: W-bit tick counter.
  - act_period, act_duty: W-bit active copies of period and duty.
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - cnt=0, act_period=0, act_duty=0.
  - pwm_out=0, cyc_done=0, busy=0.
  - Reset mid-period aborts immediately; no cyc_done is issued.
- IDLE behaviour:
  - pwm_out=0 and busy=0; tick is ignored.
  - en=1 causes, at the next edge: load act_period←period and act_duty←duty, cnt←0, state←RUN, busy←1, pwm_out←(duty≠0).
- RUN, on a cycle with tick=1:
  - If cnt ≥ act_period (end of period):
    - cnt←0 and cyc_done←1.
    - Active registers reload from the inputs (see Configuration).
    - If en=0, state←IDLE, busy←0 and pwm_out←0.
    - Otherwise pwm_out←(new act_duty > 0).
  - Otherwise: cnt←cnt+1 and pwm_out←(cnt+1 < act_duty).
- RUN with tick=0: all registers hold; cyc_done←0.
- en is examined only at period boundaries. Deasserting en mid-period finishes the current period before returning to IDLE.
- Arithmetic:
  - cnt+1 is computed at W+1 bits; cnt never wraps past act_period.
  - The comparison is unsigned.
  - duty > period gives 100 % high (pwm_out stays 1, including across boundaries).
  - duty=0 gives constant low.
  - period=0 gives a one-tick period with cyc_done on every tick.
- The ≥ test guarantees recovery if act_period is lowered below cnt (possible only with shadowing disabled): the period ends on the next tick.

## Timing
- Outputs change only on rising clk edges.
- tick sampled at edge k is reflected on cnt, pwm_out and cyc_done after edge k; latency is 1 cycle.
- cyc_done is high for exactly one clk cycle per completed period, regardless of the tick spacing.
- IDLE→RUN: busy and pwm_out are valid 1 cycle after en is sampled high.
- Back-to-back ticks (tick held high) are legal: one count per clk cycle.

## Configuration
- Macro TICK_PWM_SHADOW_EN.
- Defined:
  - period and duty are captured into act_period/act_duty only on IDLE→RUN and at each period boundary.
  - Mid-period input changes never distort the current period; glitch-free duty updates.
- Undefined:
  - act_period and act_duty load from the inputs on every clk cycle while in RUN, so changes take effect immediately.
  - The boundary reload is then a no-op.
  - The ≥ rule above applies.

## Structure
- Shared package tick_pwm_pkg holds:
  - State encoding typedef: IDLE=1'b0, RUN=1'b1.
  - Default width constant TICK_PWM_W=8.
- Sub-module: tick_pwm_cmp, a registered comparator producing pwm_out from next-cnt and next-duty. Everything else stays in the top module. The expected total is about 150–220 RTL lines.

## Test plan
- Reset and idle: rst=0 for 3 cycles, then rst=1 with en=0 and tick pulsing → pwm_out=0, busy=0, cyc_done=0 throughout.
- Basic PWM: W=8, period=9, duty=3, en=1, tick every 4th clk → per 10 ticks pwm_out high for 3 ticks and low for 7. cyc_done pulses once every 40 clk, 1 cycle wide.
- Extremes, each with tick held at 1:
  - duty=0 → pwm_out constantly 0.
  - duty=12, period=9 → pwm_out constantly 1.
  - period=0 → cyc_done high every cycle.
- Mid-period update: period=9, duty=3; at tick 5 set duty=8.
  - With TICK_PWM_SHADOW_EN defined → the current period keeps 3 high ticks and the next has 8.
  - Without it → pwm_out goes high from tick 6 to 7 in the current period.
- Stop and reset:
  - Drop en at tick 4 of period=9 → 5 more ticks, cyc_done, then busy=0, pwm_out=0.
  - Separately, rst=0 at tick 4 → busy=0 next cycle, with no cyc_done.

Source files
------------

// File: rtl/tick_pwm_pkg.sv
// tick_pwm_pkg: shared state encoding and default width for the tick-driven PWM generator
package tick_pwm_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam int TICK_PWM_W = 8;
endpackage

// File: rtl/tick_pwm_if.sv
// tick_pwm_if: control inputs and PWM outputs of tick_pwm grouped as one bus
interface tick_pwm_if import tick_pwm_pkg::*; #(parameter int W = TICK_PWM_W) ();
  logic         en;
  logic         tick;
  logic [W-1:0] period;
  logic [W-1:0] duty;
  logic         pwm_out;
  logic         cyc_done;
  logic         busy;
  modport master (output en, tick, period, duty, input pwm_out, cyc_done, busy);
  modport slave (input en, tick, period, duty, output pwm_out, cyc_done, busy);
endinterface

// File: rtl/tick_pwm_cmp.sv
// tick_pwm_cmp: registered comparator turning next count and next duty into the PWM level
module tick_pwm_cmp import tick_pwm_pkg::*; #(parameter int W = TICK_PWM_W) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         run,
  input  logic [W:0]   cnt,
  input  logic [W-1:0] duty,
  output logic         pwm
);
  // high while the upcoming tick index is below the duty; holds when not loaded
  always_ff @(posedge clk)
    if (!rst) pwm <= 1'b0;
    else if (ld) pwm <= run && (cnt < {1'b0, duty});
endmodule

// File: rtl/tick_pwm.sv
// tick_pwm: counts time-base ticks modulo a programmable period and drives a duty-controlled PWM (option TICK_PWM_SHADOW_EN)
module tick_pwm import tick_pwm_pkg::*; #(parameter int W = TICK_PWM_W) (
  input logic       clk,
  input logic       rst,
  tick_pwm_if.slave bus
);
  state_t       state, state_n;
  logic [W-1:0] cnt, cnt_n, ap, ap_n, ad, ad_n, nxt_duty;
  logic [W:0]   cnt1, nxt_cnt;
  logic         cyc, cyc_n, ld, run_n;
  assign cnt1 = {1'b0, cnt} + 1'b1;
  // state, counter, active period/duty and period-done pulse
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      ap    <= '0;
      ad    <= '0;
      cyc   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ap    <= ap_n;
      ad    <= ad_n;
      cyc   <= cyc_n;
    end
  // next state, counter and comparator operands; the >= test recovers if the period shrinks below cnt
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ap_n     = ap;
    ad_n     = ad;
    cyc_n    = 1'b0;
    ld       = 1'b0;
    run_n    = 1'b0;
    nxt_cnt  = cnt1;
    nxt_duty = ad;
`ifndef TICK_PWM_SHADOW_EN
    if (state == RUN) begin
      ap_n = bus.period;
      ad_n = bus.duty;
    end
`endif
    if (state == IDLE) begin
      ld       = 1'b1;
      run_n    = bus.en;
      nxt_cnt  = '0;
      nxt_duty = bus.duty;
      if (bus.en) begin
        state_n = RUN;
        ap_n    = bus.period;
        ad_n    = bus.duty;
        cnt_n   = '0;
      end
    end else if (bus.tick) begin
      ld = 1'b1;
      if (cnt >= ap) begin
        cnt_n    = '0;
        cyc_n    = 1'b1;
        ap_n     = bus.period;
        ad_n     = bus.duty;
        run_n    = bus.en;
        state_n  = bus.en ? RUN : IDLE;
        nxt_cnt  = '0;
        nxt_duty = bus.duty;
      end else begin
        cnt_n = cnt1[W-1:0];
        run_n = 1'b1;
      end
    end
  end
  tick_pwm_cmp #(.W(W)) u_cmp (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .run  (run_n),
    .cnt  (nxt_cnt),
    .duty (nxt_duty),
    .pwm  (bus.pwm_out)
  );
  assign bus.cyc_done = cyc;
  assign bus.busy     = (state == RUN);
endmodule

// File: tb/tb_tick_pwm.sv
// tb_tick_pwm: scoreboard bench for tick_pwm against a tick-position reference model
module tb_tick_pwm;
  typedef struct packed {logic pwm; logic cyc; logic busy;} exp_t;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   m_run = 1'b0;
  int   m_pos = 0, m_p = 0, m_d = 0;
  bit   m_pwm = 1'b0, m_cyc = 1'b0;
  tick_pwm_if #(.W(8)) bus ();
  tick_pwm #(.W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // one clk cycle of stimulus; the model position m_pos is the index of the current tick within the period
  task automatic step(input bit r, input bit e, input bit t, input int p, input int d);
    bit was_run;
    rst = r;
    bus.en = e;
    bus.tick = t;
    bus.period = p[7:0];
    bus.duty = d[7:0];
    was_run = m_run;
    m_cyc = 1'b0;
    if (!r) begin
      m_run = 1'b0; m_pos = 0; m_p = 0; m_d = 0; m_pwm = 1'b0;
    end else if (!m_run) begin
      if (e) begin
        m_run = 1'b1; m_pos = 0; m_p = p; m_d = d; m_pwm = (d != 0);
      end else m_pwm = 1'b0;
    end else begin
      if (t) begin
        if (m_pos >= m_p) begin
          m_pos = 0; m_cyc = 1'b1; m_p = p; m_d = d;
          if (!e) begin m_run = 1'b0; m_pwm = 1'b0; end
          else m_pwm = (d > 0);
        end else begin
          m_pos++;
          m_pwm = (m_pos < m_d);
        end
      end
`ifndef TICK_PWM_SHADOW_EN
      if (was_run) begin m_p = p; m_d = d; end
`endif
    end
    @(posedge clk);
    exp_q.push_back('{pwm: m_pwm, cyc: m_cyc, busy: m_run});
    #1;
  endtask
  // monitor: pops one expectation per cycle and compares away from the active edge
  always @(negedge clk)
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 3;
      if (bus.pwm_out !== e.pwm) begin errors++; $display("FAIL pwm_out t=%0t got %b want %b", $time, bus.pwm_out, e.pwm); end
      if (bus.cyc_done !== e.cyc) begin errors++; $display("FAIL cyc_done t=%0t got %b want %b", $time, bus.cyc_done, e.cyc); end
      if (bus.busy !== e.busy) begin errors++; $display("FAIL busy t=%0t got %b want %b", $time, bus.busy, e.busy); end
    end
  initial begin
    rst = 1'b0; bus.en = 1'b0; bus.tick = 1'b0; bus.period = '0; bus.duty = '0;
    #1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, i % 2 == 0, 9, 3);
    for (int i = 0; i < 400; i++) step(1, 1, i % 4 == 0, 9, 3);
    for (int i = 0; i < 40; i++) step(1, 1, 1, 9, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 1, 9, 12);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 1, 1, 9, i < 6 ? 3 : 8);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 9, 3);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 9, 3);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 9, 3);
    step(0, 1, 1, 9, 3);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 9, 3);
    begin
      int p = 5, d = 2;
      bit e = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 49) == 0) p = $urandom_range(0, 12);
        if ($urandom_range(0, 29) == 0) d = $urandom_range(0, 15);
        if ($urandom_range(0, 99) == 0) e = ~e;
        step($urandom_range(0, 499) != 0, e, $urandom_range(0, 2) != 0, p, d);
      end
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
